// File: rtl/jk_cmd_sequencer.sv
// Buffers JK commands in a small FIFO and replays them as j/k/en with setup, enable and hold windows.
// Define JKSEQ_TOGGLE_GUARD_EN to give toggle commands a single-cycle enable window.
module jk_cmd_sequencer #(
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd,
  output logic                     cmd_ready,
  output logic                     j,
  output logic                     k,
  output logic                     en,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     q_model
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int MAX_SE = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int MAXC   = (MAX_SE > HOLD_CYC) ? MAX_SE : HOLD_CYC;
  localparam int PW     = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [PW-1:0] SETUP_LD = PW'(SETUP_CYC - 1);
  localparam logic [PW-1:0] EN_LD    = PW'(EN_CYC - 1);
  localparam logic [PW-1:0] HOLD_LD  = PW'(HOLD_CYC - 1);
  localparam logic [PW-1:0] GAP_LD   = PW'(1);

`ifdef JKSEQ_TOGGLE_GUARD_EN
  localparam bit TOGGLE_GUARD = 1'b1;
`else
  localparam bit TOGGLE_GUARD = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ENABLE, S_HOLD} state_t;

  state_t          state_q;
  logic [PW-1:0]   phase_q;
  logic            j_q, k_q, en_q, q_q;
  logic [1:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;
  logic [1:0]      head;

  function automatic logic [PW-1:0] en_load(input logic [1:0] c);
    return (TOGGLE_GUARD && (c == 2'b11)) ? '0 : EN_LD;
  endfunction

  function automatic logic jk_next(input logic q, input logic jj, input logic kk);
    case ({jj, kk})
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  // No push-through: a full FIFO refuses even when a pop lands on the same edge.
  assign cmd_ready = !reset && (count_q < FULL);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && (phase_q == '0) && (count_q != '0);
  assign count_d   = count_q + CW'(push) - CW'(pop);
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= cmd;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Returning to IDLE loads a one-cycle gap so every command costs 2+SETUP+EN+HOLD cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      en_q    <= 1'b0;
      q_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (phase_q != '0) begin
            phase_q <= phase_q - 1'b1;
          end else if (pop) begin
            {j_q, k_q} <= head;
            if (SETUP_CYC > 0) begin
              state_q <= S_SETUP;
              phase_q <= SETUP_LD;
            end else begin
              state_q <= S_ENABLE;
              en_q    <= 1'b1;
              phase_q <= en_load(head);
            end
          end
        end
        S_SETUP: begin
          if (phase_q != '0) begin
            phase_q <= phase_q - 1'b1;
          end else begin
            state_q <= S_ENABLE;
            en_q    <= 1'b1;
            phase_q <= en_load({j_q, k_q});
          end
        end
        S_ENABLE: begin
          q_q <= jk_next(q_q, j_q, k_q);
          if (phase_q != '0) begin
            phase_q <= phase_q - 1'b1;
          end else begin
            en_q <= 1'b0;
            if (HOLD_CYC > 0) begin
              state_q <= S_HOLD;
              phase_q <= HOLD_LD;
            end else begin
              state_q <= S_IDLE;
              j_q     <= 1'b0;
              k_q     <= 1'b0;
              phase_q <= GAP_LD;
            end
          end
        end
        S_HOLD: begin
          if (phase_q != '0) begin
            phase_q <= phase_q - 1'b1;
          end else begin
            state_q <= S_IDLE;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            phase_q <= GAP_LD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign j          = j_q;
  assign k          = k_q;
  assign en         = en_q;
  assign q_model    = q_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: scoreboard of expected en pulses plus directed timing checks.
module tb_jk_cmd_sequencer;

`ifdef JKSEQ_TOGGLE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int EN1 = 1;
  localparam int EN2 = 3;
  localparam int W2  = GUARD ? 1 : EN2;

  logic clk = 1'b0;
  logic reset, cmd_valid, cmd_ready, j, k, en, busy, q_model;
  logic [1:0] cmd;
  logic [2:0] fifo_count;
  logic rst2, valid2, ready2, j2, k2, en2, busy2, q2;
  logic [1:0] cmd2;
  logic [2:0] count2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0] jk;
    logic       q;
    int         width;
  } sb_t;
  sb_t  sb_q[$];
  int   rise_q[$];
  logic q_exp = 1'b0;

  bit         mon_en_prev = 1'b0;
  int         mon_w = 0;
  logic [1:0] mon_jk = 2'b00;
  sb_t        mon_e;

  jk_cmd_sequencer #(.DEPTH(4), .SETUP_CYC(1), .EN_CYC(EN1), .HOLD_CYC(1)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .j(j), .k(k), .en(en), .busy(busy), .fifo_count(fifo_count), .q_model(q_model)
  );

  jk_cmd_sequencer #(.DEPTH(4), .SETUP_CYC(0), .EN_CYC(EN2), .HOLD_CYC(0)) u_dut2 (
    .clk(clk), .reset(rst2), .cmd_valid(valid2), .cmd(cmd2), .cmd_ready(ready2),
    .j(j2), .k(k2), .en(en2), .busy(busy2), .fifo_count(count2), .q_model(q2)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [1:0] c);
    sb_t e;
    int  w;
    w = (GUARD && c == 2'b11) ? 1 : EN1;
    case (c)
      2'b01: q_exp = 1'b0;
      2'b10: q_exp = 1'b1;
      2'b11: for (int i = 0; i < w; i++) q_exp = ~q_exp;
      default: ;
    endcase
    e.jk = c; e.q = q_exp; e.width = w;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    if (cmd_ready) sb_push(c);
  endtask

  // Pulse monitor: pops one expected entry per completed en pulse.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      mon_en_prev = 1'b0;
      mon_w = 0;
    end else begin
      if (en) begin
        if (!mon_en_prev) begin
          mon_jk = {j, k};
          rise_q.push_back(cyc);
          mon_w = 0;
        end else begin
          chk("en_jk_stable", {j, k}, mon_jk);
        end
        mon_w++;
      end else if (mon_en_prev) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_pulse", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_jk", mon_jk, mon_e.jk);
          chk("sb_q_model", q_model, mon_e.q);
          chk("sb_en_width", mon_w, mon_e.width);
        end
      end
      mon_en_prev = en;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  found;
    logic [1:0] seq [5];
    seq[0] = 2'b11; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00; seq[4] = 2'b10;

    reset = 1'b1; rst2 = 1'b1;
    cmd_valid = 1'b0; cmd = 2'b00; valid2 = 1'b0; cmd2 = 2'b00;
    repeat (3) tick();
    chk("rst_ready", cmd_ready, 0);
    chk("rst_jk_en", {j, k, en}, 0);
    chk("rst_q", q_model, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    reset = 1'b0; rst2 = 1'b0;
    tick();
    chk("rel_ready", cmd_ready, 1);
    chk("rel_ready2", ready2, 1);

    // Second instance: SETUP=0, HOLD=0, EN=3; toggle from q=0 then set.
    valid2 = 1'b1; cmd2 = 2'b11;
    tick();
    cmd2 = 2'b10;
    tick();
    valid2 = 1'b0;
    chk("d2_en_rise", en2, 1);
    chk("d2_jk_toggle", {j2, k2}, 2'b11);
    chk("d2_count", count2, 1);
    for (int i = 1; i < W2; i++) begin
      tick();
      chk("d2_en_hold", en2, 1);
    end
    tick();
    chk("d2_en_fall", en2, 0);
    chk("d2_jk_clear", {j2, k2}, 0);
    chk("d2_q_toggle", q2, 1);
    tick();
    chk("d2_gap", en2, 0);
    tick();
    chk("d2_en_rise2", en2, 1);
    chk("d2_jk_set", {j2, k2}, 2'b10);
    repeat (3) tick();
    chk("d2_en_fall2", en2, 0);
    chk("d2_q_set", q2, 1);
    chk("d2_j_clear2", j2, 0);
    chk("d2_busy", busy2, 0);

    // Single set on the default instance.
    drive(2'b10);
    tick();
    cmd_valid = 1'b0;
    chk("t0_count", fifo_count, 1);
    tick();
    chk("t1_jk", {j, k}, 2'b10);
    chk("t1_en", en, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t2_en", en, 1);
    tick();
    chk("t3_en", en, 0);
    chk("t3_q", q_model, 1);
    chk("t3_j", j, 1);
    tick();
    chk("t4_j", j, 0);
    chk("t4_busy", busy, 0);
    tick();

    // Fill the FIFO while a command is in flight; the fifth push is refused.
    rise_q.delete();
    drive(2'b10);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd = seq[i];
      if (i == 4) begin
        chk("full_count", fifo_count, 4);
        chk("full_ready", cmd_ready, 0);
      end
      if (cmd_ready) sb_push(seq[i]);
      tick();
    end
    cmd_valid = 1'b0;
    chk("pop_count", fifo_count, 3);
    chk("pop_ready", cmd_ready, 1);

    n = 0;
    while ((busy || sb_q.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_busy", busy, 0);
    chk("drain_sb", sb_q.size(), 0);
    chk("rise_count", rise_q.size(), 5);
    for (int i = 1; i < rise_q.size(); i++)
      chk("en_spacing", rise_q[i] - rise_q[i-1], 5);
    chk("seq_q_final", q_model, 0);
    tick();

    // Reset during ENABLE with three commands queued.
    drive(2'b10);
    tick();
    drive(2'b11); tick();
    drive(2'b10); tick();
    drive(2'b00); tick();
    drive(2'b01); tick();
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (en && fifo_count == 3) found = 1'b1;
      else tick();
    end
    chk("pre_rst_state_seen", found, 1);
    chk("pre_rst_q", q_model, 1);
    reset = 1'b1;
    sb_q.delete();
    q_exp = 1'b0;
    tick();
    chk("abort_en", en, 0);
    chk("abort_jk", {j, k}, 0);
    chk("abort_count", fifo_count, 0);
    chk("abort_q", q_model, 0);
    chk("abort_ready", cmd_ready, 0);
    tick();
    chk("abort_ready_hold", cmd_ready, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
- Upstream driver for the JK latch stage. Accepts JK commands (hold/reset/set/toggle) over a valid/ready handshake and buffers them in a small FIFO.
- Replays each command as latch control signals j, k, en with guaranteed setup, enable and hold windows, so the latch never sees j/k change while en is high.
- Keeps q_model, a cycle-accurate prediction of the latch output, for checking against the latch.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, ≥2)
- SETUP_CYC, 1, cycles j/k are stable before en rises (0 allowed)
- EN_CYC, 1, cycles en is high per command (≥1)
- HOLD_CYC, 1, cycles j/k are held after en falls (0 allowed)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  reset, synchronous, active-high
- cmd_valid  input  1  command present
- cmd  input  2  {j,k}: 00 hold, 01 reset, 10 set, 11 toggle
- cmd_ready  output  1  FIFO can accept a command
- j  output  1  latch J, registered
- k  output  1  latch K, registered
- en  output  1  latch enable, registered
- busy  output  1  FSM not in IDLE, or FIFO not empty
- fifo_count  output  $clog2(DEPTH)+1  entries held
- q_model  output  1  predicted latch q

Behaviour:
- Reset (sampled at posedge):
  - FIFO flushed; fifo_count=0; FSM enters IDLE.
  - j=k=en=0, q_model=0, busy=0.
  - cmd_ready=0 while reset is high; cmd_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation aborts the command in flight immediately: en drops on the same edge, and queued commands are lost.
- Handshake:
  - Push occurs when cmd_valid && cmd_ready at posedge.
  - cmd_ready = (fifo_count < DEPTH), combinational from registered count.
  - When full, cmd_ready=0 even if a pop happens on the same edge (no push-through).
  - Push and pop on the same edge with count not full: count unchanged, data order preserved.
  - Read/write pointers wrap modulo DEPTH.
- FSM states: IDLE, SETUP, ENABLE, HOLD.
- IDLE:
  - If fifo_count>0: pop the head and load j,k from cmd.
  - Go to SETUP if SETUP_CYC>0; otherwise go to ENABLE and set en=1 on the same edge.
  - Otherwise stay; j=k=en=0.
- SETUP:
  - Hold for SETUP_CYC cycles, with en=0 and j/k stable.
  - Then go to ENABLE and set en=1.
- ENABLE:
  - en=1 for EN_CYC cycles.
  - q_model updates on every edge that ends an en=1 cycle: 00 keep, 01 →0, 10 →1, 11 invert.
  - Then en=0 and go to HOLD if HOLD_CYC>0; otherwise go to IDLE with j=k=0.
- HOLD:
  - Hold for HOLD_CYC cycles, with en=0 and j/k stable.
  - Then j=k=0 and go to IDLE.
- Cadence: a pop is allowed only from IDLE, so back-to-back commands take 2+SETUP_CYC+EN_CYC+HOLD_CYC cycles each (5 at defaults).
- Phase counter is clog2(max(SETUP_CYC,EN_CYC,HOLD_CYC))+1 bits, reloaded on each state entry.
- Invariant: j/k change only on edges where en is 0 before and after the edge.

Optional Feature:
- Macro: JKSEQ_TOGGLE_GUARD_EN.
- When defined: a toggle command (11) uses an enable window of exactly 1 cycle regardless of EN_CYC, so q_model inverts exactly once per toggle. Other commands still use EN_CYC.
- When undefined: all commands use EN_CYC, and a toggle inverts q_model EN_CYC times (models real latch oscillation).

Test Plan:
- Reset then a single set at edge T (defaults):
  - j=1,k=0 after T+1; en=1 after T+2; en=0 and q_model=1 after T+3; j=0 after T+4; busy=0 after T+4.
- Push 5 commands in 5 consecutive cycles with DEPTH=4:
  - The 5th is refused (cmd_ready=0 while fifo_count=4).
  - After the next pop, fifo_count drops to 3 and cmd_ready returns to 1.
- Sequence set, toggle, toggle, reset, hold:
  - q_model goes 1, 0, 1, 0, 0.
  - en pulses spaced exactly 5 cycles apart.
- SETUP_CYC=0, HOLD_CYC=0, EN_CYC=2, command set:
  - en rises on the pop edge and is high 2 cycles.
  - j=0 on the same edge en falls; back-to-back period is 4 cycles.
- EN_CYC=3, toggle from q_model=0:
  - Without the guard macro: q_model=1 after 3 inversions.
  - With JKSEQ_TOGGLE_GUARD_EN: en high 1 cycle, q_model=1.
- Assert reset during ENABLE with 3 queued commands:
  - Next cycle: en=0, j=k=0, fifo_count=0, q_model=0, cmd_ready=0 until reset releases.
